// File: rtl/game_state_ctrl.sv
// Screen-state controller: START / GAME / END, with every change aligned to frame_start.
// Also emits a game reset pulse and counts the frames played in the current game.
module game_state_ctrl #(
  parameter int END_FRAMES  = 180,
  parameter int LOCK_FRAMES = 30
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        frame_start,
  input  logic        key_start,
  input  logic        game_over,
  output logic [1:0]  state,
  output logic        game_rst,
  output logic        state_chg,
  output logic [15:0] game_frames
);

  localparam logic [1:0] S_START = 2'd0;
  localparam logic [1:0] S_GAME  = 2'd1;
  localparam logic [1:0] S_END   = 2'd2;

  localparam logic [7:0] END_LAST = 8'(END_FRAMES - 1);
  localparam logic [7:0] LOCK_CNT = 8'(LOCK_FRAMES);

  logic [1:0]  state_reg, state_next;
  logic        key_d_reg;
  logic        req_start_reg, req_over_reg;
  logic [7:0]  end_cnt_reg, end_cnt_next;
  logic [15:0] frames_reg, frames_next;
  logic        game_rst_reg, game_rst_next;
  logic        state_chg_reg, state_chg_next;

  logic key_edge;
  logic eff_start;
  logic eff_over;

  assign key_edge  = key_start & ~key_d_reg;
  assign eff_start = req_start_reg | key_edge;
  assign eff_over  = req_over_reg | game_over;

  // State register and all other sequential state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= S_START;
      key_d_reg     <= 1'b1;
      req_start_reg <= 1'b0;
      req_over_reg  <= 1'b0;
      end_cnt_reg   <= 8'd0;
      frames_reg    <= 16'd0;
      game_rst_reg  <= 1'b0;
      state_chg_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      key_d_reg     <= key_start;
      // Requests live only until the next frame boundary, used or not.
      req_start_reg <= frame_start ? 1'b0 : (req_start_reg | key_edge);
      req_over_reg  <= frame_start ? 1'b0 : (req_over_reg | game_over);
      end_cnt_reg   <= end_cnt_next;
      frames_reg    <= frames_next;
      game_rst_reg  <= game_rst_next;
      state_chg_reg <= state_chg_next;
    end
  end

  // Next-state logic: only frame boundaries may change the screen.
  always_comb begin
    state_next = state_reg;
    if (frame_start) begin
      case (state_reg)
        S_START: if (eff_start) state_next = S_GAME;
        S_GAME:  if (eff_over)  state_next = S_END;
        S_END: begin
          if (end_cnt_reg == END_LAST)
            state_next = S_START;
          else if (eff_start && (end_cnt_reg >= LOCK_CNT))
            state_next = S_GAME;
        end
        default: state_next = S_START;
      endcase
    end
  end

  // Pulses and counters derived from the current/next state pair.
  always_comb begin
    game_rst_next  = (state_next == S_GAME) && (state_reg != S_GAME);
    state_chg_next = (state_next != state_reg);

    end_cnt_next = end_cnt_reg;
    if ((state_next == S_END) && (state_reg != S_END))
      end_cnt_next = 8'd0;
    else if (frame_start && (state_reg == S_END) && (state_next == S_END))
      end_cnt_next = end_cnt_reg + 8'd1;

    // The frame that enters GAME clears the count; the frame that leaves it is not counted.
    frames_next = frames_reg;
    if ((state_next == S_GAME) && (state_reg != S_GAME))
      frames_next = 16'd0;
    else if (frame_start && (state_reg == S_GAME) && (state_next == S_GAME) &&
             (frames_reg != 16'hFFFF))
      frames_next = frames_reg + 16'd1;
  end

  assign state       = state_reg;
  assign game_rst    = game_rst_reg;
  assign state_chg   = state_chg_reg;
  assign game_frames = frames_reg;

endmodule

// File: tb/tb_game_state_ctrl.sv
// Bench for game_state_ctrl: a table of per-cycle vectors followed by
// hand-written multi-frame sequences (END timeout, lock window, saturation, reset).
module tb_game_state_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        frame_start;
  logic        key_start;
  logic        game_over;
  logic [1:0]  state;
  logic        game_rst;
  logic        state_chg;
  logic [15:0] game_frames;

  int checks = 0;
  int errors = 0;

  game_state_ctrl #(.END_FRAMES(180), .LOCK_FRAMES(30)) dut (
    .clk         (clk),
    .rst         (rst),
    .frame_start (frame_start),
    .key_start   (key_start),
    .game_over   (game_over),
    .state       (state),
    .game_rst    (game_rst),
    .state_chg   (state_chg),
    .game_frames (game_frames)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        fs;
    logic        key;
    logic        go;
    logic [1:0]  st;
    logic        grst;
    logic        chg;
    logic [15:0] fr;
  } vec_t;

  vec_t tbl [16];

  function automatic vec_t mk(input logic r, fs, k, go, input logic [1:0] st,
                              input logic g, c, input logic [15:0] f);
    vec_t v;
    v.rst = r; v.fs = fs; v.key = k; v.go = go;
    v.st = st; v.grst = g; v.chg = c; v.fr = f;
    return v;
  endfunction

  // Apply inputs for one cycle; outputs are sampled 1 time unit after the edge.
  task automatic step(input logic r, fs, k, go);
    rst = r; frame_start = fs; key_start = k; game_over = go;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_out(input string name, input logic [1:0] st, input logic g, c,
                         input logic [15:0] f);
    chk({name, ".state"}, 32'(state), 32'(st));
    chk({name, ".game_rst"}, 32'(game_rst), 32'(g));
    chk({name, ".state_chg"}, 32'(state_chg), 32'(c));
    chk({name, ".game_frames"}, 32'(game_frames), 32'(f));
  endtask

  task automatic frame();
    step(1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic press();
    step(1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    rst = 1'b1; frame_start = 1'b0; key_start = 1'b0; game_over = 1'b0;

    //            rst   fs    key   go    st    grst  chg   frames
    tbl[0]  = mk(1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 16'd0);
    tbl[1]  = mk(1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 1'b0, 1'b0, 16'd0);
    tbl[2]  = mk(1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 16'd0);
    tbl[3]  = mk(1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 16'd0);
    tbl[4]  = mk(1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 16'd0);
    tbl[5]  = mk(1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 16'd0);
    tbl[6]  = mk(1'b0, 1'b1, 1'b0, 1'b0, 2'd1, 1'b1, 1'b1, 16'd0);
    tbl[7]  = mk(1'b0, 1'b0, 1'b0, 1'b0, 2'd1, 1'b0, 1'b0, 16'd0);
    tbl[8]  = mk(1'b0, 1'b1, 1'b0, 1'b0, 2'd1, 1'b0, 1'b0, 16'd1);
    tbl[9]  = mk(1'b0, 1'b0, 1'b1, 1'b0, 2'd1, 1'b0, 1'b0, 16'd1);
    tbl[10] = mk(1'b0, 1'b1, 1'b0, 1'b0, 2'd1, 1'b0, 1'b0, 16'd2);
    tbl[11] = mk(1'b0, 1'b0, 1'b0, 1'b0, 2'd1, 1'b0, 1'b0, 16'd2);
    tbl[12] = mk(1'b0, 1'b0, 1'b0, 1'b1, 2'd1, 1'b0, 1'b0, 16'd2);
    tbl[13] = mk(1'b0, 1'b1, 1'b0, 1'b0, 2'd2, 1'b0, 1'b1, 16'd2);
    tbl[14] = mk(1'b0, 1'b0, 1'b0, 1'b0, 2'd2, 1'b0, 1'b0, 16'd2);
    tbl[15] = mk(1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 16'd0);

    for (int i = 0; i < 16; i++) begin
      step(tbl[i].rst, tbl[i].fs, tbl[i].key, tbl[i].go);
      chk_out($sformatf("vec%0d", i), tbl[i].st, tbl[i].grst, tbl[i].chg, tbl[i].fr);
      $display("vec %0d: rst=%b fs=%b key=%b go=%b -> state=%0d grst=%b chg=%b frames=%0d",
               i, tbl[i].rst, tbl[i].fs, tbl[i].key, tbl[i].go,
               state, game_rst, state_chg, game_frames);
    end

    // Game of 10 frames, then game_over mid-frame.
    step(1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    chk_out("enter_game", 2'd1, 1'b1, 1'b1, 16'd0);
    for (int i = 0; i < 10; i++) frame();
    chk_out("ten_frames", 2'd1, 1'b0, 1'b0, 16'd10);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    chk_out("game_over", 2'd2, 1'b0, 1'b1, 16'd10);
    $display("seq game_over: state=%0d frames=%0d", state, game_frames);

    // END held exactly 180 frame_starts with the key idle.
    for (int i = 1; i < 180; i++) begin
      frame();
      chk($sformatf("end_hold%0d", i), 32'(state), 32'd2);
    end
    frame();
    chk_out("end_timeout", 2'd0, 1'b0, 1'b1, 16'd10);
    $display("seq end_timeout: state=%0d frames=%0d", state, game_frames);

    // New game of 3 frames, then the lock-window boundary in END.
    press();
    step(1'b0, 1'b1, 1'b0, 1'b0);
    chk_out("regame", 2'd1, 1'b1, 1'b1, 16'd0);
    for (int i = 0; i < 3; i++) frame();
    step(1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    chk_out("end2_entry", 2'd2, 1'b0, 1'b1, 16'd3);
    for (int i = 0; i < 5; i++) frame();
    press();
    step(1'b0, 1'b1, 1'b0, 1'b0);
    chk_out("lock_cnt5", 2'd2, 1'b0, 1'b0, 16'd3);
    for (int i = 6; i < 29; i++) frame();
    press();
    step(1'b0, 1'b1, 1'b0, 1'b0);
    chk_out("lock_cnt29", 2'd2, 1'b0, 1'b0, 16'd3);
    press();
    step(1'b0, 1'b1, 1'b0, 1'b0);
    chk_out("unlock_cnt30", 2'd1, 1'b1, 1'b1, 16'd0);
    $display("seq lock: state=%0d frames=%0d", state, game_frames);

    // Key edge and game_over on the frame_start itself: game_over wins.
    frame();
    chk("game_frame1", 32'(game_frames), 32'd1);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b1);
    chk_out("same_cycle", 2'd2, 1'b0, 1'b1, 16'd1);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    chk_out("same_cycle_after", 2'd2, 1'b0, 1'b0, 16'd1);
    for (int i = 1; i < 180; i++) frame();
    chk("end3_hold", 32'(state), 32'd2);
    // Key on the last END frame: timeout has priority.
    step(1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b0);
    chk_out("timeout_priority", 2'd0, 1'b0, 1'b1, 16'd1);
    $display("seq priority: state=%0d frames=%0d", state, game_frames);

    // Key held high through reset release: no edge, stays in START.
    step(1'b1, 1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b1, 1'b1, 1'b0);
      chk_out($sformatf("held_key%0d", i), 2'd0, 1'b0, 1'b0, 16'd0);
    end

    // Long game: continuous frame_start to reach saturation.
    step(1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b0);
    chk_out("sat_entry", 2'd1, 1'b1, 1'b1, 16'd0);
    for (int i = 0; i < 65534; i++) step(1'b0, 1'b1, 1'b0, 1'b0);
    chk("sat_65534", 32'(game_frames), 32'd65534);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    chk("sat_65535", 32'(game_frames), 32'hFFFF);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1'b0, 1'b0);
    chk_out("sat_hold", 2'd1, 1'b0, 1'b0, 16'hFFFF);
    $display("seq saturate: state=%0d frames=%0h", state, game_frames);

    // Reset mid-frame with pending requests: everything returns to reset values.
    step(1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b1, 1'b1);
    chk_out("mid_reset", 2'd0, 1'b0, 1'b0, 16'd0);
    step(1'b0, 1'b1, 1'b1, 1'b0);
    chk_out("post_reset_frame", 2'd0, 1'b0, 1'b0, 16'd0);
    $display("seq reset: state=%0d frames=%0h", state, game_frames);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
